intersection_phase_scheduler: RTL and testbench

Central sequencer for the four-light intersection. It latches pedestrian and turn requests and picks the next phase by fixed rotation. It drives go commands to the per-direction trafficlight instances and uses each light's green/red status as a handshake, so conflicting lights are never commanded together and every direction is served within a bounded time.

---
 rtl/traffic_pkg.sv | 52 +++++
 rtl/request_latch.sv | 33 +++
 rtl/intersection_phase_scheduler.sv | 164 ++++++++++++++++
 tb/tb_intersection_phase_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase/state types, light indices and phase light masks
//               for the intersection sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    typedef enum logic [1:0] {
        STRAIGHT = 2'd0,
        TURN     = 2'd1,
        PED      = 2'd2
    } phase_t;

    typedef enum logic [2:0] {
        ALLRED = 3'd0,
        GO     = 3'd1,
        HOLD   = 3'd2,
        STOP   = 3'd3,
        FAULT  = 3'd4
    } sched_state_t;

    localparam int LIGHT_UP   = 0;
    localparam int LIGHT_DOWN = 1;
    localparam int LIGHT_TURN = 2;
    localparam int LIGHT_PED  = 3;

    localparam logic [3:0] MASK_STRAIGHT = 4'((1 << LIGHT_UP) | (1 << LIGHT_DOWN));
    localparam logic [3:0] MASK_TURN     = 4'((1 << LIGHT_UP) | (1 << LIGHT_TURN));
    localparam logic [3:0] MASK_PED      = 4'(1 << LIGHT_PED);

    function automatic logic [3:0] phase_mask(input phase_t p);
        case (p)
            STRAIGHT: return MASK_STRAIGHT;
            TURN:     return MASK_TURN;
            PED:      return MASK_PED;
            default:  return 4'b0000;
        endcase
    endfunction

    // TURN always hands back to STRAIGHT so the down light cannot starve.
    function automatic phase_t next_phase(input phase_t cur, input logic ped, input logic turn);
        case (cur)
            STRAIGHT: return ped ? PED : (turn ? TURN : STRAIGHT);
            PED:      return turn ? TURN : STRAIGHT;
            default:  return STRAIGHT;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/request_latch.sv
`default_nettype none
// ============================================================================
// Module      : request_latch
// Description : Sticky request flop; set wins over clear, inhibit freezes it.
// Revision    : 1.0 - initial release
// ============================================================================
module request_latch (
    input  logic clock,
    input  logic reset_n,
    input  logic i_set,
    input  logic i_clear,
    input  logic i_inhibit,
    output logic o_pending
);

    logic r_pending;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (!i_inhibit) begin
            if (i_set) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intersection_phase_scheduler
// Description : Rotating phase sequencer using light green/red status as a
//               handshake before commanding the next phase.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME  = 4,
    parameter int ALLRED_TIME = 1,
    parameter int WAIT_MAX    = 8,
    parameter int CNT_W       = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pedestrian_button,
    input  logic       turn_sensor,
    input  logic [3:0] light_green,
    input  logic [3:0] light_red,
    output logic [3:0] light_go,
    output logic [1:0] phase,
    output logic       hold_active,
    output logic       fault
);

    localparam logic [CNT_W-1:0] c_allred_last = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] c_wait_last   = CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

    sched_state_t     r_state, w_state_next;
    phase_t           r_phase, w_phase_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [3:0]       r_go, w_go_next;
    logic             r_hold, w_hold_next;
    logic             r_fault, w_fault_next;
    logic [3:0]       w_mask;
    logic             w_ped_pend, w_turn_pend;
    logic             w_enter_hold;

    assign w_mask       = phase_mask(r_phase);
    assign w_enter_hold = (r_state == GO) && (w_state_next == HOLD);

    request_latch u_ped_latch (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_set     (pedestrian_button),
        .i_clear   (w_enter_hold && (r_phase == PED)),
        .i_inhibit ((r_state == HOLD) && (r_phase == PED)),
        .o_pending (w_ped_pend)
    );

    request_latch u_turn_latch (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_set     (turn_sensor),
        .i_clear   (w_enter_hold && (r_phase == TURN)),
        .i_inhibit ((r_state == HOLD) && (r_phase == TURN)),
        .o_pending (w_turn_pend)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ALLRED;
            r_phase <= STRAIGHT;
            r_cnt   <= '0;
            r_go    <= 4'b0000;
            r_hold  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_cnt   <= w_cnt_next;
            r_go    <= w_go_next;
            r_hold  <= w_hold_next;
            r_fault <= w_fault_next;
        end
    end

    // Compares stop one short of the limit so the counter never exceeds it.
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_cnt_next   = r_cnt;
        case (r_state)
            ALLRED: begin
                if (light_red == 4'b1111) begin
                    if (r_cnt == c_allred_last) begin
                        w_state_next = GO;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_one;
                    end
                end else begin
                    w_cnt_next = '0;
                end
            end
            GO: begin
                if ((light_green & w_mask) == w_mask) begin
                    w_state_next = HOLD;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_wait_last) begin
                    w_state_next = FAULT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end
            HOLD: begin
                if (r_cnt == c_green_last) begin
                    w_state_next = STOP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end
            STOP: begin
                if ((light_red & w_mask) == w_mask) begin
                    w_state_next = ALLRED;
                    w_phase_next = next_phase(r_phase, w_ped_pend, w_turn_pend);
                    w_cnt_next   = '0;
                end else if (r_cnt == c_wait_last) begin
                    w_state_next = FAULT;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + c_one;
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next = FAULT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they only
    // move on a transition and never glitch between phases.
    always_comb begin
        w_go_next    = 4'b0000;
        w_hold_next  = 1'b0;
        w_fault_next = 1'b0;
        case (w_state_next)
            GO:      w_go_next = phase_mask(w_phase_next);
            HOLD: begin
                w_go_next   = phase_mask(w_phase_next);
                w_hold_next = 1'b1;
            end
            FAULT:   w_fault_next = 1'b1;
            default: w_go_next = 4'b0000;
        endcase
    end

    assign light_go    = r_go;
    assign phase       = r_phase;
    assign hold_active = r_hold;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_phase_scheduler
// Description : Scoreboard bench with a phase-level reference model and a
//               simple light model answering the go handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_scheduler;

    localparam int GREEN_TIME = 4;
    localparam int WAIT_MAX   = 8;
    localparam int BOUND      = 25;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pedestrian_button = 1'b0;
    logic       turn_sensor = 1'b0;
    logic [3:0] light_green, light_red, light_go;
    logic [1:0] phase;
    logic       hold_active, fault;

    logic [3:0] r_green = 4'b0000;
    logic [3:0] r_red = 4'b1111;
    logic [3:0] r_go_d = 4'b0000;
    logic [3:0] stuck_red = 4'b0000;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q[$];
    int cur_phase = 0;
    bit pend_ped = 0, pend_turn = 0, turn_held = 0;
    int ped_req_cyc = -1, turn_req_cyc = -1;
    bit gap_en = 0;
    int t0;

    intersection_phase_scheduler #(
        .GREEN_TIME (4),
        .ALLRED_TIME(1),
        .WAIT_MAX   (8),
        .CNT_W      (4)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .pedestrian_button(pedestrian_button),
        .turn_sensor      (turn_sensor),
        .light_green      (light_green),
        .light_red        (light_red),
        .light_go         (light_go),
        .phase            (phase),
        .hold_active      (hold_active),
        .fault            (fault)
    );

    always #5 clock = ~clock;

    // Lights: green one cycle after go, red two cycles after go drops.
    always @(posedge clock) begin
        r_green <= light_go;
        r_go_d  <= light_go;
        r_red   <= ~light_go & ~r_go_d;
        cyc     <= cyc + 1;
    end
    assign light_green = r_green;
    assign light_red   = r_red & ~stuck_red;

    function automatic int exp_mask(input int p);
        case (p)
            0: return 3;
            1: return 5;
            2: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_vec++;
        if (act > lim) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, required <= %0d (cycle %0d)", name, act, lim, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic wait_hold(input logic lvl, input string what);
        int n;
        n = 0;
        while (hold_active !== lvl) begin
            @(negedge clock);
            n++;
            if (n > 60) begin
                n_vec++;
                n_err++;
                $display("FAIL timeout_%s: hold_active=%0b, required %0b within 60 cycles", what, hold_active, lvl);
                finish_run();
            end
        end
    endtask

    // Phase rotation rule applied to the model's own pending flags.
    task automatic predict_next();
        int nxt;
        if (turn_held) pend_turn = 1;
        case (cur_phase)
            0: nxt = pend_ped ? 2 : (pend_turn ? 1 : 0);
            2: nxt = pend_turn ? 1 : 0;
            default: nxt = 0;
        endcase
        if (nxt == 2) pend_ped = 0;
        if (nxt == 1) pend_turn = 0;
        cur_phase = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic serve(input int ped_pct, input int turn_pct);
        bit ped, turn;
        wait_hold(1'b1, "hold_entry");
        ped  = ($urandom_range(99) < ped_pct);
        turn = ($urandom_range(99) < turn_pct) && !turn_held;
        if (ped || turn) begin
            repeat ($urandom_range(2)) @(negedge clock);
            pedestrian_button = ped;
            if (turn) turn_sensor = 1'b1;
            if (ped && cur_phase != 2) begin
                pend_ped = 1;
                if (ped_req_cyc < 0) ped_req_cyc = cyc;
            end
            if (turn && cur_phase != 1) begin
                pend_turn = 1;
                if (turn_req_cyc < 0) turn_req_cyc = cyc;
            end
            @(negedge clock);
            pedestrian_button = 1'b0;
            if (turn) turn_sensor = 1'b0;
        end
        wait_hold(1'b0, "hold_exit");
        predict_next();
    endtask

    task automatic do_reset();
        gap_en = 0;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 check("async_go_drop", int'(light_go), 0);
        repeat (3) @(negedge clock);
        check("rst_phase", int'(phase), 0);
        check("rst_light_go", int'(light_go), 0);
        check("rst_hold_active", int'(hold_active), 0);
        check("rst_fault", int'(fault), 0);
        reset_n = 1'b1;
        exp_q.delete();
        pend_ped = 0;
        pend_turn = 0;
        ped_req_cyc = -1;
        turn_req_cyc = -1;
        cur_phase = 0;
        exp_q.push_back(0);
        gap_en = 1;
    endtask

    initial begin : monitor
        int e, hold_len, down_gap;
        bit prev_hold;
        prev_hold = 0;
        hold_len = 0;
        down_gap = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_hold = 0;
                hold_len = 0;
                down_gap = 0;
            end else begin
                check("down_turn_conflict", int'(light_go[1] & light_go[2]), 0);
                check("ped_conflict", int'(light_go[3] && (light_go[2:0] != 3'b000)), 0);
                if (hold_active && !prev_hold) begin
                    hold_len = 1;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_hold: phase %0d entered HOLD, required none", phase);
                    end else begin
                        e = exp_q.pop_front();
                        check("phase", int'(phase), e);
                        check("light_go", int'(light_go), exp_mask(e));
                        if (e == 2 && ped_req_cyc >= 0) begin
                            check_le("ped_latency", cyc - ped_req_cyc, BOUND);
                            ped_req_cyc = -1;
                        end
                        if (e == 1 && turn_req_cyc >= 0) begin
                            check_le("turn_latency", cyc - turn_req_cyc, BOUND);
                            turn_req_cyc = -1;
                        end
                    end
                end else if (hold_active) begin
                    hold_len++;
                end else if (prev_hold) begin
                    check("hold_len", hold_len, GREEN_TIME);
                end
                if (!gap_en) begin
                    down_gap = 0;
                end else if (light_green[1]) begin
                    if (down_gap > 0) check_le("down_green_gap", down_gap, BOUND);
                    down_gap = 0;
                end else begin
                    down_gap++;
                end
                prev_hold = hold_active;
            end
        end
    end

    initial begin : stimulus
        do_reset();

        // Idle rotation stays on STRAIGHT.
        repeat (4) serve(0, 0);

        // Single pedestrian pulse during a STRAIGHT hold.
        while (cur_phase != 0) serve(0, 0);
        serve(100, 0);
        repeat (2) serve(0, 0);

        // Pedestrian and turn in the same cycle.
        while (cur_phase != 0) serve(0, 0);
        serve(100, 100);
        repeat (3) serve(0, 0);

        // Turn sensor held high for at least 100 cycles.
        while (cur_phase != 0) serve(0, 0);
        wait_hold(1'b1, "turn_level_start");
        turn_sensor = 1'b1;
        turn_held = 1;
        turn_req_cyc = cyc;
        t0 = cyc;
        wait_hold(1'b0, "turn_level_start_exit");
        predict_next();
        while (!((cyc - t0) >= 100 && cur_phase == 0)) serve(0, 0);
        wait_hold(1'b1, "turn_level_end");
        turn_sensor = 1'b0;
        turn_held = 0;
        pend_turn = 1;
        wait_hold(1'b0, "turn_level_end_exit");
        predict_next();

        // Randomised request mix.
        repeat (30) serve(30, 30);

        // Down light never reports red after its go drops.
        while (cur_phase != 0) serve(0, 0);
        wait_hold(1'b1, "fault_hold");
        stuck_red = 4'b0010;
        gap_en = 0;
        wait_hold(1'b0, "fault_stop");
        repeat (7) @(negedge clock);
        check("fault_before_timeout", int'(fault), 0);
        @(negedge clock);
        check("fault_at_timeout", int'(fault), 1);
        check("fault_light_go", int'(light_go), 0);
        stuck_red = 4'b0000;
        repeat (6) @(negedge clock);
        check("fault_sticky", int'(fault), 1);
        check("fault_sticky_go", int'(light_go), 0);
        check("fault_no_hold", int'(hold_active), 0);
        do_reset();

        // Reset in the middle of a PED hold with a turn request latched.
        while (cur_phase != 0) serve(0, 0);
        serve(100, 0);
        wait_hold(1'b1, "ped_hold_for_reset");
        turn_sensor = 1'b1;
        @(negedge clock);
        turn_sensor = 1'b0;
        do_reset();
        repeat (3) serve(0, 0);

        repeat (4) @(negedge clock);
        finish_run();
    end

endmodule
`default_nettype wire
